// File: rtl/fill_cmd_queue.sv
// Pushbutton-driven command queue: synchronises and debounces an active-low start button and,
// on each debounced press, enqueues {size,vectors} into a show-ahead FIFO.
module fill_cmd_queue #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned LOG_DEPTH       = 3,
  parameter int unsigned WIDTH           = 6
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [2:0]         i_size,
  input  logic [2:0]         i_vectors,
  input  logic               i_rdreq,
  output logic [WIDTH-1:0]   o_q,
  output logic               o_rdempty,
  output logic               o_wrfull,
  output logic [LOG_DEPTH:0] o_usedw,
  output logic               o_drop,
  output logic [7:0]         o_accepted
);

  localparam int unsigned        Depth   = 2 ** LOG_DEPTH;
  localparam logic [7:0]         CntLast = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [LOG_DEPTH:0] FullCnt = (LOG_DEPTH + 1)'(Depth);

  logic                 r_s1, r_s2, r_db, r_press;
  logic [7:0]           r_cnt;
  logic [LOG_DEPTH-1:0] r_wptr, r_rptr;
  logic [LOG_DEPTH:0]   r_usedw;
  logic                 r_rdempty, r_wrfull, r_drop;
  logic [7:0]           r_accepted;
  logic [WIDTH-1:0]     r_mem [Depth];

  logic                 w_valid, w_wr, w_rd;
  logic [LOG_DEPTH:0]   w_usedw_nxt;

  // Button is active-low; the synchroniser carries the pressed (high) level.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_db    <= 1'b0;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_s1    <= ~i_start;
      r_s2    <= r_s1;
      r_press <= 1'b0;
      if (r_s2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CntLast) begin
        r_db    <= r_s2;
        r_cnt   <= '0;
        r_press <= r_s2;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  // A full queue still accepts a press when the same cycle pops the head.
  assign w_valid = (i_size != 3'd0) && (i_vectors != 3'd0);
  assign w_wr    = r_press && w_valid && (!r_wrfull || i_rdreq);
  assign w_rd    = i_rdreq && !r_rdempty;

  always_comb begin
    w_usedw_nxt = r_usedw;
    if (w_wr && !w_rd) begin
      w_usedw_nxt = r_usedw + 1'b1;
    end else if (w_rd && !w_wr) begin
      w_usedw_nxt = r_usedw - 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_usedw    <= '0;
      r_rdempty  <= 1'b1;
      r_wrfull   <= 1'b0;
      r_drop     <= 1'b0;
      r_accepted <= '0;
    end else begin
      if (w_wr) begin
        r_wptr     <= r_wptr + LOG_DEPTH'(1);
        r_accepted <= r_accepted + 8'd1;
      end
      if (w_rd) begin
        r_rptr <= r_rptr + LOG_DEPTH'(1);
      end
      r_usedw   <= w_usedw_nxt;
      r_rdempty <= (w_usedw_nxt == '0);
      r_wrfull  <= (w_usedw_nxt == FullCnt);
      r_drop    <= r_press && !w_wr;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= WIDTH'({i_size, i_vectors});
    end
  end

  assign o_q        = r_rdempty ? '0 : r_mem[r_rptr];
  assign o_rdempty  = r_rdempty;
  assign o_wrfull   = r_wrfull;
  assign o_usedw    = r_usedw;
  assign o_drop     = r_drop;
  assign o_accepted = r_accepted;

endmodule

// File: tb/tb_fill_cmd_queue.sv
// Bench for fill_cmd_queue: directed table rows and corner sequences, then random traffic,
// all cycle-checked against a queue-based reference model.
module tb_fill_cmd_queue;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       reset, start, rdreq;
  logic [2:0] size, vectors;
  logic [5:0] q;
  logic       rdempty, wrfull, drop;
  logic [3:0] usedw;
  logic [7:0] accepted;

  fill_cmd_queue #(.DEBOUNCE_CYCLES(DB), .LOG_DEPTH(3), .WIDTH(6)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_size(size), .i_vectors(vectors),
    .i_rdreq(rdreq), .o_q(q), .o_rdempty(rdempty), .o_wrfull(wrfull), .o_usedw(usedw),
    .o_drop(drop), .o_accepted(accepted)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int drop_cnt = 0;

  // Reference model: synchronizer delay line, sliding window of synchronized samples,
  // and a plain queue of entries.
  bit         m_s1, m_s2, m_db, m_press, m_drop;
  bit         win[$];
  logic [5:0] mq[$];
  int         m_acc;

  task automatic model_update();
    bit rd, wr, all_dis;
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_db = 0; m_press = 0; m_drop = 0;
      win.delete(); mq.delete(); m_acc = 0;
      return;
    end
    rd = rdreq && (mq.size() > 0);
    wr = m_press && (size != 0) && (vectors != 0) && ((mq.size() < 8) || rdreq);
    m_drop = m_press && !wr;
    if (rd) void'(mq.pop_front());
    if (wr) begin
      mq.push_back({size, vectors});
      m_acc = (m_acc + 1) % 256;
    end
    // Level flips once DB consecutive synchronized samples disagree with it.
    win.push_back(m_s2);
    if (win.size() > DB) void'(win.pop_front());
    all_dis = (win.size() == DB);
    foreach (win[i]) if (win[i] == m_db) all_dis = 0;
    m_press = 0;
    if (all_dis) begin
      m_db = !m_db;
      m_press = m_db;
    end
    m_s2 = m_s1;
    m_s1 = !start;
  endtask

  task automatic compare();
    logic [5:0] eq;
    eq = (mq.size() > 0) ? mq[0] : 6'd0;
    n_vec++;
    if (usedw !== 4'(mq.size()) || rdempty !== (mq.size() == 0) || wrfull !== (mq.size() == 8)
        || q !== eq || drop !== m_drop || accepted !== 8'(m_acc)) begin
      n_err++;
      $display("FAIL model t=%0t: got usedw=%0d rdempty=%b wrfull=%b q=%b drop=%b acc=%0d; want usedw=%0d rdempty=%b wrfull=%b q=%b drop=%b acc=%0d",
               $time, usedw, rdempty, wrfull, q, drop, accepted, mq.size(), mq.size() == 0,
               mq.size() == 8, eq, m_drop, m_acc);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
    if (drop === 1'b1) drop_cnt++;
  endtask

  task automatic press_release(input logic [2:0] s, input logic [2:0] v);
    size = s; vectors = v; start = 1'b0;
    repeat (7) step();
    start = 1'b1;
    repeat (7) step();
  endtask

  typedef struct {
    logic [2:0] size;
    logic [2:0] vec;
    int         exp_usedw;
    int         exp_acc;
    int         exp_drops;
    logic       exp_full;
  } row_t;

  row_t       rows[11];
  logic [2:0] drain_v[8];
  int         seg;

  initial begin
    rows[0] = '{3'd1, 3'd0, 0, 1, 1, 1'b0};
    rows[1] = '{3'd0, 3'd3, 0, 1, 1, 1'b0};
    for (int i = 0; i < 8; i++)
      rows[2 + i] = '{3'd1, 3'((i % 7) + 1), i + 1, i + 2, 0, (i == 7)};
    rows[10] = '{3'd1, 3'd2, 8, 9, 1, 1'b1};

    // Reset held with the button already pressed, then released.
    reset = 1'b1; start = 1'b0; size = 3'd2; vectors = 3'd4; rdreq = 1'b0;
    repeat (2) step();
    chk("reset_rdempty", rdempty, 1);
    chk("reset_usedw", usedw, 0);
    chk("reset_q", q, 0);
    reset = 1'b0;
    repeat (6) step();
    chk("first_press_latency_usedw", usedw, 0);
    step();
    chk("first_press_usedw", usedw, 1);
    chk("first_press_q", q, 6'b010100);
    chk("first_press_rdempty", rdempty, 0);
    chk("first_press_acc", accepted, 1);
    start = 1'b1;
    repeat (7) step();
    rdreq = 1'b1; step(); rdreq = 1'b0;

    // Short bounces never reach the debounce threshold.
    drop_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      start = 1'b0; repeat (2) step();
      start = 1'b1; repeat (3) step();
    end
    repeat (5) step();
    chk("bounce_usedw", usedw, 0);
    chk("bounce_drops", drop_cnt, 0);
    chk("bounce_acc", accepted, 1);

    for (int r = 0; r < 11; r++) begin
      drop_cnt = 0;
      press_release(rows[r].size, rows[r].vec);
      chk($sformatf("row%0d_usedw", r), usedw, rows[r].exp_usedw);
      chk($sformatf("row%0d_acc", r), accepted, rows[r].exp_acc);
      chk($sformatf("row%0d_drops", r), drop_cnt, rows[r].exp_drops);
      chk($sformatf("row%0d_wrfull", r), wrfull, rows[r].exp_full);
    end

    // Press on a full queue coinciding with a pop.
    size = 3'd1; vectors = 3'd5; start = 1'b0;
    repeat (6) step();
    rdreq = 1'b1; step(); rdreq = 1'b0;
    chk("full_rw_usedw", usedw, 8);
    chk("full_rw_drop", drop, 0);
    chk("full_rw_q", q, 6'b001010);
    chk("full_rw_acc", accepted, 10);
    start = 1'b1;
    repeat (7) step();
    drain_v = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1, 3'd5};
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d_q", i), q, {3'd1, drain_v[i]});
      rdreq = 1'b1; step();
    end
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("empty_rd%0d_usedw", i), usedw, 0);
      chk($sformatf("empty_rd%0d_q", i), q, 0);
    end
    rdreq = 1'b0;

    // Reset in the middle of a debounce with three entries queued.
    for (int i = 0; i < 3; i++) press_release(3'd3, 3'd3);
    chk("pre_reset_usedw", usedw, 3);
    size = 3'd2; vectors = 3'd4; start = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    #1;
    chk("midreset_usedw", usedw, 0);
    chk("midreset_rdempty", rdempty, 1);
    chk("midreset_acc", accepted, 0);
    chk("midreset_q", q, 0);
    repeat (2) step();
    reset = 1'b0;
    repeat (6) step();
    chk("post_reset_no_write", usedw, 0);
    step();
    chk("post_reset_press_usedw", usedw, 1);
    chk("post_reset_press_acc", accepted, 1);
    start = 1'b1;
    repeat (7) step();

    // Random traffic against the model.
    seg = 0;
    for (int c = 0; c < 2000; c++) begin
      if (seg == 0) begin
        start = 1'($urandom_range(0, 1));
        seg = $urandom_range(1, 12);
      end
      seg--;
      size = 3'($urandom_range(0, 7));
      vectors = 3'($urandom_range(0, 7));
      rdreq = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
